// File: rtl/assert_pkg.sv
// assert_pkg: shared types for the assertion check scheduler
package assert_pkg;
    localparam int OP_W = 2;
    typedef enum logic [OP_W-1:0] {OP_ROSE, OP_FELL, OP_STABLE, OP_RSVD} op_e;
    typedef enum logic [1:0] {IDLE, ARM, RUN, REPORT} sched_state_e;
endpackage

// File: rtl/assert_sched_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after rr_ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             any
);
    always_comb begin
        grant = '0;
        grant_id = '0;
        any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (en && req[(int'(rr_ptr) + i) % N_REQ]) begin
                grant = '0;
                grant[(int'(rr_ptr) + i) % N_REQ] = 1'b1;
                grant_id = ID_W'((int'(rr_ptr) + i) % N_REQ);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/assert_sched_ctrl.sv
// assert_sched_ctrl: time-shared rose/fell/stable evaluator with round-robin request arbitration
module assert_sched_ctrl
    import assert_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8,
    parameter int ID_W = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0][OP_W-1:0]  req_op,
    input  logic [N_REQ-1:0][CNT_W-1:0] req_win,
    input  logic                        signal_in,
    output logic [N_REQ-1:0]            gnt,
    output logic                        busy,
    output logic                        done,
    output logic [ID_W-1:0]             done_id,
    output logic                        pass,
    output logic [CNT_W-1:0]            hit_cnt
);
    sched_state_e state, state_nx;
    op_e op_q;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0] gid, rr_ptr, id_q;
    logic [CNT_W-1:0] win_q, win_cnt, hits, hits_nx;
    logic any, prev, hit, miss, last;
    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req(req), .rr_ptr(rr_ptr), .en(state == IDLE),
        .grant(grant), .grant_id(gid), .any(any)
    );
    always_comb begin
        hit = op_q == OP_ROSE ? ~prev & signal_in : op_q == OP_FELL ? prev & ~signal_in : prev == signal_in;
        hits_nx = &hits ? hits : hits + CNT_W'(hit);
        miss = op_q == OP_STABLE && !hit;
        last = win_cnt == CNT_W'(1) || miss;
        state_nx = state == IDLE ? (any ? ARM : IDLE)
                 : state == ARM  ? (op_q == OP_RSVD ? REPORT : RUN)
                 : state == RUN  ? (last ? REPORT : RUN)
                 : IDLE;
    end
    assign done = state == REPORT;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            gnt <= '0;
            pass <= 1'b0;
            done_id <= '0;
            hit_cnt <= '0;
        end else begin
            state <= state_nx;
            gnt <= grant;
            if (state == IDLE && any) begin
                op_q <= op_e'(req_op[gid]);
                win_q <= req_win[gid];
                id_q <= gid;
                rr_ptr <= gid == ID_W'(N_REQ - 1) ? '0 : gid + 1'b1;
            end
            if (state == ARM) begin
                prev <= signal_in;
                win_cnt <= win_q == '0 ? CNT_W'(1) : win_q;
                hits <= '0;
                if (op_q == OP_RSVD) begin
                    pass <= 1'b0;
                    hit_cnt <= '0;
                    done_id <= id_q;
                end
            end
            if (state == RUN) begin
                prev <= signal_in;
                win_cnt <= win_cnt - 1'b1;
                hits <= hits_nx;
                if (last) begin
                    pass <= op_q == OP_STABLE ? hit : hits_nx != '0;
                    hit_cnt <= hits_nx;
                    done_id <= id_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_assert_sched_ctrl.sv
// tb_assert_sched_ctrl: directed checks of arbitration, evaluation, boundaries and reset
module tb_assert_sched_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signal_in = 1'b0;
    logic [3:0] req = '0, req4 = '0;
    logic [3:0][1:0] req_op = '0, req_op4 = '0;
    logic [3:0][7:0] req_win = '0;
    logic [3:0][3:0] req_win4 = '0;
    logic [3:0] gnt, gnt4;
    logic busy, done, pass, busy4, done4, pass4;
    logic [1:0] done_id, done_id4;
    logic [7:0] hit_cnt;
    logic [3:0] hit_cnt4;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assert_sched_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_win(req_win),
        .signal_in(signal_in), .gnt(gnt), .busy(busy), .done(done),
        .done_id(done_id), .pass(pass), .hit_cnt(hit_cnt)
    );

    assert_sched_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .req_op(req_op4), .req_win(req_win4),
        .signal_in(signal_in), .gnt(gnt4), .busy(busy4), .done(done4),
        .done_id(done_id4), .pass(pass4), .hit_cnt(hit_cnt4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_pass", 32'(pass), 32'h0);
        chk("rst_id", 32'(done_id), 32'h0);
        chk("rst_hits", 32'(hit_cnt), 32'h0);
        rst = 1'b0;

        // rose, one pulse: ARM sample 0, RUN 0,1,1,0,0
        req[0] = 1'b1; req_op[0] = 2'b00; req_win[0] = 8'd5; signal_in = 1'b0;
        step();
        chk("rose_gnt", 32'(gnt), 32'h1);
        chk("rose_busy", 32'(busy), 32'h1);
        req[0] = 1'b0; signal_in = 1'b0;
        step();
        signal_in = 1'b0; step();
        signal_in = 1'b1; step();
        signal_in = 1'b1; step();
        signal_in = 1'b0; step();
        chk("rose_nodone_early", 32'(done), 32'h0);
        signal_in = 1'b0; step();
        chk("rose_done", 32'(done), 32'h1);
        chk("rose_pass", 32'(pass), 32'h1);
        chk("rose_hits", 32'(hit_cnt), 32'h1);
        chk("rose_id", 32'(done_id), 32'h0);
        step();
        chk("rose_idle_busy", 32'(busy), 32'h0);
        chk("rose_done_pulse", 32'(done), 32'h0);
        chk("rose_pass_held", 32'(pass), 32'h1);

        // stable with a miss in RUN cycle 3
        req[2] = 1'b1; req_op[2] = 2'b10; req_win[2] = 8'd8; signal_in = 1'b1;
        step();
        chk("stab_gnt", 32'(gnt), 32'h4);
        req[2] = 1'b0;
        step();
        step();
        step();
        signal_in = 1'b0;
        step();
        chk("stab_done", 32'(done), 32'h1);
        chk("stab_pass", 32'(pass), 32'h0);
        chk("stab_hits", 32'(hit_cnt), 32'h2);
        chk("stab_id", 32'(done_id), 32'h2);
        step();
        chk("stab_idle", 32'(busy), 32'h0);

        rst = 1'b1; step(); rst = 1'b0;

        // round robin: all request, each drops after its grant
        req = 4'b1111; req_op = '0; req_win = {8'd1, 8'd1, 8'd1, 8'd1};
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(4'b0001 << i));
            req[i] = 1'b0;
            step();
            chk($sformatf("rr_nognt%0d", i), 32'(gnt), 32'h0);
            step();
            chk($sformatf("rr_done%0d", i), 32'(done), 32'h1);
            chk($sformatf("rr_id%0d", i), 32'(done_id), 32'(i));
            step();
        end

        // window 0 behaves as 1
        req[1] = 1'b1; req_op[1] = 2'b10; req_win[1] = 8'd0; signal_in = 1'b0;
        step();
        chk("w0_gnt", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        step();
        chk("w0_run_busy", 32'(busy), 32'h1);
        step();
        chk("w0_done", 32'(done), 32'h1);
        chk("w0_pass", 32'(pass), 32'h1);
        chk("w0_hits", 32'(hit_cnt), 32'h1);
        chk("w0_id", 32'(done_id), 32'h1);
        step();

        // reserved op reports immediately
        req[2] = 1'b1; req_op[2] = 2'b11; req_win[2] = 8'd9;
        step();
        chk("rsvd_gnt", 32'(gnt), 32'h4);
        req[2] = 1'b0;
        step();
        chk("rsvd_done", 32'(done), 32'h1);
        chk("rsvd_pass", 32'(pass), 32'h0);
        chk("rsvd_hits", 32'(hit_cnt), 32'h0);
        chk("rsvd_id", 32'(done_id), 32'h2);
        step();
        chk("rsvd_idle", 32'(busy), 32'h0);

        // rose over 255 cycles with toggling input, reference sample 1
        req[3] = 1'b1; req_op[3] = 2'b00; req_win[3] = 8'd255;
        step();
        chk("tog_gnt", 32'(gnt), 32'h8);
        req[3] = 1'b0; signal_in = 1'b1;
        step();
        for (int k = 1; k <= 255; k++) begin
            signal_in = (k % 2 == 1) ? 1'b0 : 1'b1;
            step();
        end
        chk("tog_done", 32'(done), 32'h1);
        chk("tog_pass", 32'(pass), 32'h1);
        chk("tog_hits", 32'(hit_cnt), 32'd127);
        chk("tog_id", 32'(done_id), 32'h3);
        step();

        // 4-bit counter, stable over the maximum window
        req4[0] = 1'b1; req_op4[0] = 2'b10; req_win4[0] = 4'd15; signal_in = 1'b1;
        step();
        chk("sat_gnt", 32'(gnt4), 32'h1);
        req4[0] = 1'b0;
        for (int k = 0; k < 16; k++) step();
        chk("sat_done", 32'(done4), 32'h1);
        chk("sat_pass", 32'(pass4), 32'h1);
        chk("sat_hits", 32'(hit_cnt4), 32'd15);
        step();

        // reset during RUN cycle 2 discards the check
        req[1] = 1'b1; req_op[1] = 2'b10; req_win[1] = 8'd8; signal_in = 1'b1;
        step();
        chk("mr_gnt", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_done", 32'(done), 32'h0);
        chk("mr_gnt0", 32'(gnt), 32'h0);
        chk("mr_pass", 32'(pass), 32'h0);
        chk("mr_hits", 32'(hit_cnt), 32'h0);
        chk("mr_id", 32'(done_id), 32'h0);
        rst = 1'b0;
        req = 4'b1001; req_win[0] = 8'd1;
        step();
        chk("mr_prio", 32'(gnt), 32'h1);
        req = '0;
        step();
        step();
        step();
        chk("mr_idle", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
